// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: decoder state encoding and framing pulse counts,
// used by both the receive decoder and the transmit path.
package maple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA_A = 3'd2,
        ST_DATA_B = 3'd3,
        ST_END    = 3'd4
    } maple_state_e;

    localparam int START_PULSES = 4;
    localparam int END_PULSES   = 2;

    localparam int PULSE_W = 3;
    typedef logic [PULSE_W-1:0] pulse_cnt_t;

    // Saturating increment so a long pulse train cannot wrap back to a legal count.
    function automatic pulse_cnt_t pulse_inc(input pulse_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + pulse_cnt_t'(1);
    endfunction

endpackage

// File: rtl/maple_rx_fifo.sv
// First-word-fall-through byte FIFO for decoded Maple data; a full FIFO still
// accepts a push when a pop happens in the same cycle.
module maple_rx_fifo
    import maple_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_clear,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (w_count == '0);
    assign o_full    = w_count[AW];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | i_pop);
    assign o_data    = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/maple_in.sv
// Maple bus receive decoder: synchronises SDCKA/SDCKB, decodes start pattern,
// alternating-phase data bits and end pattern, and buffers bytes in a FIFO.
module maple_in
    import maple_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic        in_p1,
    input  logic        in_p5,
    input  logic        rx_pop,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow,
    output logic [10:0] byte_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic r_p1_s1, r_p1_cur, r_p1_prev;
    logic r_p5_s1, r_p5_cur, r_p5_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_p1_s1, r_p1_cur, r_p1_prev} <= 3'b111;
            {r_p5_s1, r_p5_cur, r_p5_prev} <= 3'b111;
        end else begin
            {r_p1_s1, r_p1_cur, r_p1_prev} <= {in_p1, r_p1_s1, r_p1_cur};
            {r_p5_s1, r_p5_cur, r_p5_prev} <= {in_p5, r_p5_s1, r_p5_cur};
        end
    end

    logic w_p1_fall, w_p1_rise, w_p5_fall, w_p5_rise;
    logic w_p1_edge, w_p5_edge;

    assign w_p1_fall = r_p1_prev & ~r_p1_cur;
    assign w_p1_rise = ~r_p1_prev & r_p1_cur;
    assign w_p5_fall = r_p5_prev & ~r_p5_cur;
    assign w_p5_rise = ~r_p5_prev & r_p5_cur;
    assign w_p1_edge = r_p1_prev ^ r_p1_cur;
    assign w_p5_edge = r_p5_prev ^ r_p5_cur;

    maple_state_e r_state, w_next_state;
    pulse_cnt_t   r_pulse_cnt, w_pulse_nxt;
    logic [2:0]   r_bit_cnt, w_bit_nxt;
    logic [6:0]   r_shift;
    logic [10:0]  r_byte_count;
    logic [TW-1:0] r_tmo_cnt;
    logic         r_done, r_err, r_ovf;
    logic         w_timeout, w_set_err, w_set_done, w_start;
    logic         w_bit_valid, w_bit_value, w_push;
    logic [7:0]   w_byte;
    logic         w_fifo_empty, w_fifo_full;

    assign w_timeout = (r_tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE || w_p1_edge || w_p5_edge) begin
            r_tmo_cnt <= '0;
        end else if (!w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pulse_nxt  = r_pulse_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_bit_valid  = 1'b0;
        w_bit_value  = 1'b0;
        w_set_err    = 1'b0;
        w_set_done   = 1'b0;
        w_start      = 1'b0;

        if (!enable) begin
            w_next_state = ST_IDLE;
        end else if (r_state != ST_IDLE && ((w_p1_edge && w_p5_edge) || w_timeout)) begin
            w_set_err    = 1'b1;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_p1_fall && r_p5_cur && r_p5_prev) begin
                        w_next_state = ST_START;
                        w_pulse_nxt  = '0;
                        w_start      = 1'b1;
                    end
                end
                ST_START: begin
                    if (w_p1_rise) begin
                        if (r_pulse_cnt == pulse_cnt_t'(START_PULSES)) begin
                            w_next_state = ST_DATA_A;
                            w_bit_nxt    = '0;
                        end else begin
                            w_set_err    = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end else if (w_p5_fall && !r_p1_cur) begin
                        w_pulse_nxt = pulse_inc(r_pulse_cnt);
                    end
                end
                ST_DATA_A: begin
                    if (w_p1_fall) begin
                        w_bit_valid  = 1'b1;
                        w_bit_value  = r_p5_cur;
                        w_next_state = ST_DATA_B;
                    end else if (w_p5_fall && r_p1_cur) begin
                        w_next_state = ST_END;
                        w_pulse_nxt  = '0;
                    end
                end
                ST_DATA_B: begin
                    if (w_p5_fall) begin
                        w_bit_valid  = 1'b1;
                        w_bit_value  = r_p1_cur;
                        w_next_state = ST_DATA_A;
                    end
                end
                ST_END: begin
                    if (w_p5_rise) begin
                        if (r_pulse_cnt == pulse_cnt_t'(END_PULSES) && r_bit_cnt == 3'd0) begin
                            w_set_done = 1'b1;
                        end else begin
                            w_set_err = 1'b1;
                        end
                        w_next_state = ST_IDLE;
                    end else if (w_p1_fall && !r_p5_cur) begin
                        if (r_pulse_cnt == pulse_cnt_t'(END_PULSES)) begin
                            w_set_err    = 1'b1;
                            w_next_state = ST_IDLE;
                        end else begin
                            w_pulse_nxt = pulse_inc(r_pulse_cnt);
                        end
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end

        // The 3-bit counter wraps 7 -> 0 on the eighth bit, so every byte restarts in DATA_A.
        if (w_bit_valid) w_bit_nxt = r_bit_cnt + 3'd1;
    end

    assign w_byte = {r_shift, w_bit_value};
    assign w_push = w_bit_valid && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pulse_cnt  <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pulse_cnt <= w_pulse_nxt;
            r_bit_cnt   <= w_bit_nxt;
            if (w_bit_valid) r_shift <= w_byte[6:0];
            if (clear) begin
                r_byte_count <= '0;
                r_done       <= 1'b0;
                r_err        <= 1'b0;
                r_ovf        <= 1'b0;
            end else begin
                if (w_set_err)  r_err  <= 1'b1;
                if (w_set_done) r_done <= 1'b1;
                if (w_push && w_fifo_full && !rx_pop) r_ovf <= 1'b1;
                if (w_start) begin
                    r_byte_count <= '0;
                end else if (w_push && r_byte_count != 11'h7FF) begin
                    r_byte_count <= r_byte_count + 11'd1;
                end
            end
        end
    end

    maple_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (rx_pop),
        .i_clear (clear),
        .i_data  (w_byte),
        .o_data  (rx_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign rx_valid   = ~w_fifo_empty;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign overflow   = r_ovf;
    assign byte_count = r_byte_count;

endmodule

// File: doc/maple_in.md
# maple_in

Receive-side decoder for the Maple bus, the counterpart of the register-driven output path. It watches the synchronised SDCKA/SDCKB levels (`in_p1`/`in_p5` from the selected physical port), detects the start pattern, decodes the alternating-phase bit stream into bytes, and detects the end pattern. Decoded bytes are buffered in a FIFO that SPI register glue drains, and frame status flags are exposed the same way.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥ 2.
- `TIMEOUT`, 4095: idle `clk` cycles allowed between line edges inside a frame before the frame is aborted.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: decoder runs when 1; when 0 the FSM is held in IDLE.
- `clear` in 1: one-cycle pulse; flushes FIFO, clears sticky flags and `byte_count`.
- `in_p1` in 1: SDCKA line level, asynchronous.
- `in_p5` in 1: SDCKB line level, asynchronous.
- `rx_pop` in 1: consume head byte; ignored when empty.
- `rx_data` out 8: FIFO head byte; valid when `rx_valid`.
- `rx_valid` out 1: FIFO non-empty.
- `busy` out 1: FSM is not IDLE.
- `frame_done` out 1: sticky; a frame ended with a valid end pattern.
- `frame_err` out 1: sticky; malformed frame or timeout.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `byte_count` out 11: bytes decoded in the current or last frame; saturates at 2047.

## Operation
- Inputs pass through a 2-flop synchroniser, then a third register for edge detection. A "fall" is prev=1, cur=0.
- FSM states:
  - **IDLE**: wait for both lines high, then a p1 fall with p5 high. Go to START, zero the pulse counter, zero `byte_count`.
  - **START**: count p5 falls while p1 is low. On a p1 rise: if count == 4, go to DATA_A with bit count 0; otherwise set `frame_err` and go to IDLE.
  - **DATA_A**:
    - On a p1 fall, shift in p5 (MSB first) and go to DATA_B.
    - On a p5 fall with p1 high, go to END and zero the pulse counter.
  - **DATA_B**: on a p5 fall, shift in p1 and go to DATA_A.
  - On the 8th bit, push the byte to the FIFO, increment `byte_count`, and reset the bit count. Every byte therefore starts in DATA_A.
  - **END**: count p1 falls while p5 is low. On a p5 rise:
    - if count == 2 and bit count == 0, set `frame_done`;
    - otherwise set `frame_err`.
    - Either way, go to IDLE.
- Errors set `frame_err` and return the FSM to IDLE. Bytes already pushed stay in the FIFO. Error conditions:
  - both lines change in the same sample;
  - the timeout counter reaches `TIMEOUT` in any non-IDLE state;
  - in END, a p1 fall arrives when the count is already 2.
- The timeout counter reloads on any edge and runs only outside IDLE.
- FIFO behaviour:
  - Push when full: byte is dropped and `overflow` is set, except when `rx_pop` is asserted in the same cycle. In that case both the pop and the push happen.
  - Pop when empty: no effect.
- `clear` has priority over a same-cycle push or pop. It does not change FSM state.
- `enable` falling mid-frame forces IDLE without setting any flag.

## Timing
- Reset values: FSM = IDLE; synchroniser flops = 1; FIFO empty; `rx_valid`, `busy`, `frame_done`, `frame_err`, `overflow` = 0; `byte_count` = 0; `rx_data` = 0.
- Pin-to-edge latency is 3 `clk`. A byte is visible on `rx_valid`/`rx_data` 1 cycle after the decoding edge is detected.
- `rx_data` is first-word-fall-through. After `rx_pop`, the next byte appears the following cycle.
- Sticky flags set 1 cycle after the causing edge.
- The line must hold each level for ≥ 2 `clk`; faster toggling is out of spec and may be reported via `frame_err`.

## Structure
- Put these in a shared `maple_pkg` so the transmit side uses the same values:
  - FSM state encoding (IDLE, START, DATA_A, DATA_B, END);
  - `START_PULSES` = 4 and `END_PULSES` = 2.
- Implement the FIFO as a sub-module `maple_rx_fifo` (parameter DEPTH; push/pop/clear; data/empty/full). The decoder FSM, synchroniser and counters live in `maple_in`.

## Test plan
- Send a frame of start pattern, bytes 0xA5, 0x3C, end pattern, then pop twice. Expect `rx_data` 0xA5 then 0x3C, `frame_done`=1, `byte_count`=2, `frame_err`=0.
- Send a start pattern with only 3 p5 pulses. Expect `frame_err`=1, FSM back in IDLE, FIFO empty.
- Send 0xFF followed by 5 bits, then the end pattern. Expect one byte 0xFF in the FIFO, `frame_err`=1, `frame_done`=0.
- With DEPTH=16 and no pops, send 17 bytes. Expect 16 bytes buffered, `overflow`=1, and the 17th byte absent. Repeat with `rx_pop` asserted on the 17th push cycle: no overflow.
- Send a start pattern plus 3 bits, then hold the lines still for `TIMEOUT` cycles. Expect `frame_err`=1 and `busy`=0. Pulse `clear`: all flags 0, `byte_count`=0.
- Assert `rst` mid-byte, then release and send a fresh frame with 0x81. Expect all outputs at reset values, then a clean decode of 0x81.
